// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between writeback (priority) and a buffered long-latency result stream.
// Optional zero-latency bypass of an empty buffer is enabled by defining REGWR_BYPASS_EN.
module regfile_wr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_waddr,
    input  logic [DATA_W-1:0]        wb_wdata,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [ADDR_W-1:0]        lu_waddr,
    input  logic [DATA_W-1:0]        lu_wdata,
    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    input  logic [ADDR_W-1:0]        dec_raddr1,
    input  logic [ADDR_W-1:0]        dec_raddr2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  occ;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [SC_W-1:0]   starve_cnt;

    logic full, empty, accept, wb_sel, pop, bypass, store, kill_en;
    logic hit1, hit2;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign lu_ready = !full && !rst;
    assign accept   = lu_valid && lu_ready;
    assign wb_sel   = wb_we && !stall_req;
    assign pop      = !wb_sel && !empty && !rst;
`ifdef REGWR_BYPASS_EN
    assign bypass   = accept && empty && !wb_we;
`else
    assign bypass   = 1'b0;
`endif
    assign store    = accept && (lu_waddr != '0) && !bypass;
    // A writeback dropped during a stall must not kill the buffered copy it failed to overwrite.
    assign kill_en  = wb_sel && (wb_waddr != '0);
    assign pend_cnt = count;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        occ  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
            if (occ[i] && live[i] && (addr_mem[i] == dec_raddr1)) hit1 = 1'b1;
            if (occ[i] && live[i] && (addr_mem[i] == dec_raddr2)) hit2 = 1'b1;
        end
    end

    assign hazard1 = hit1 && (dec_raddr1 != '0);
    assign hazard2 = hit2 && (dec_raddr2 != '0);

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (!rst) begin
            if (wb_sel) begin
                we    = 1'b1;
                waddr = wb_waddr;
                wdata = wb_wdata;
            end else if (!empty) begin
                we    = live[rd_ptr];
                waddr = addr_mem[rd_ptr];
                wdata = data_mem[rd_ptr];
            end else if (bypass) begin
                we    = (lu_waddr != '0);
                waddr = lu_waddr;
                wdata = lu_wdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            live       <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && live[i] && (addr_mem[i] == wb_waddr)) live[i] <= 1'b0;
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PTR_W'(1);
            end
            // Written after the kill loop: a same-cycle accept is newer than the writeback.
            if (store) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            case ({store, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop)
                starve_cnt <= '0;
            else if (full && (starve_cnt < SC_W'(STARVE_MAX)))
                starve_cnt <= starve_cnt + SC_W'(1);
            stall_req <= !pop && (starve_cnt >= SC_W'(STARVE_MAX));
        end
    end

    // NOTE: the payload array has no reset; validity is carried entirely by count and live.
    always_ff @(posedge clk) begin
        if (store) begin
            addr_mem[wr_ptr] <= lu_waddr;
            data_mem[wr_ptr] <= lu_wdata;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: vector table, scoreboarded random stream, and
// hand-written reset / starvation / bypass sequences.
module tb_regfile_wr_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] dec_raddr1;
    logic [ADDR_W-1:0] dec_raddr2;
    logic              hazard1;
    logic              hazard2;
    logic              stall_req;
    logic [1:0]        pend_cnt;

    int tests = 0;
    int fails = 0;

    regfile_wr_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .dec_raddr1(dec_raddr1), .dec_raddr2(dec_raddr2),
        .hazard1(hazard1), .hazard2(hazard2),
        .stall_req(stall_req), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wbwe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        luv;
        logic [4:0]  lua;
        logic [31:0] lud;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic [1:0]  ep;
        logic        eh1;
        logic        eh2;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[13];
    wr_t  sb_q[$];
    logic sb_en = 1'b0;
    logic [31:0] rf [32] = '{default: 32'h0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        wb_we = wv; wb_waddr = wa; wb_wdata = wd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    endtask

    // Register file shadow written from the DUT's port, to observe final contents.
    always @(posedge clk) begin
        if (!rst && we) rf[waddr] <= wdata;
    end

    // Scoreboard: accepted results are queued, then matched in order against port writes.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (lu_valid && lu_ready && (lu_waddr != '0))
                sb_q.push_back('{a: lu_waddr, d: lu_wdata});
            if (we) begin
                if (wb_we) begin
                    check("sb_wb_addr", 64'(waddr), 64'(wb_waddr));
                    check("sb_wb_data", 64'(wdata), 64'(wb_wdata));
                end else if (sb_q.size() == 0) begin
                    check("sb_unexpected_write", 64'(waddr), 64'hFFFF);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("sb_lu_addr", 64'(waddr), 64'(e.a));
                    check("sb_lu_data", 64'(wdata), 64'(e.d));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise_k;

        vecs[0]  = '{1'b1, 5'd5, 32'h1111, 1'b1, 5'd6, 32'h2222, 5'd0, 5'd0, 1'b1, 5'd5, 32'h1111, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 5'd6, 32'h2222, 2'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hAAAA, 5'd7, 5'd0, 1'b0, 5'd0, 32'h0,    2'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'h0,    5'd7, 5'd0, 1'b1, 5'd7, 32'hBBBB, 2'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd7, 5'd0, 1'b0, 5'd0, 32'h0,    2'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd7, 5'd0, 1'b0, 5'd0, 32'h0,    2'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd8, 32'h88,   5'd0, 5'd8, 1'b0, 5'd0, 32'h0,    2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 32'h0,    5'd0, 5'd8, 1'b1, 5'd2, 32'h22,   2'd1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd8, 1'b1, 5'd8, 32'h88,   2'd1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd8, 1'b0, 5'd0, 32'h0,    2'd0, 1'b0, 1'b0};

        // Reset state, with an active writeback that must be masked.
        rst = 1'b1;
        dec_raddr1 = 5'd1; dec_raddr2 = 5'd0;
        drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd2, 32'h66);
        #2;
        check("rst_we", 64'(we), 64'd0);
        check("rst_waddr", 64'(waddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_lu_ready", 64'(lu_ready), 64'd0);
        check("rst_pend", 64'(pend_cnt), 64'd0);
        check("rst_hazard1", 64'(hazard1), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        dec_raddr1 = 5'd0;
        tick(); tick();
        rst = 1'b0;

`ifndef REGWR_BYPASS_EN
        // Vector table: priority, WAW kill, address zero, hazards.
        for (int i = 0; i < 13; i++) begin
            tick();
            drive(vecs[i].wbwe, vecs[i].wba, vecs[i].wbd, vecs[i].luv, vecs[i].lua, vecs[i].lud);
            dec_raddr1 = vecs[i].r1;
            dec_raddr2 = vecs[i].r2;
            @(negedge clk);
            check($sformatf("vec%0d_we", i), 64'(we), 64'(vecs[i].ewe));
            if (vecs[i].ewe) begin
                check($sformatf("vec%0d_waddr", i), 64'(waddr), 64'(vecs[i].ea));
                check($sformatf("vec%0d_wdata", i), 64'(wdata), 64'(vecs[i].ed));
            end
            check($sformatf("vec%0d_pend", i), 64'(pend_cnt), 64'(vecs[i].ep));
            check($sformatf("vec%0d_ready", i), 64'(lu_ready), 64'd1);
            check($sformatf("vec%0d_hazard1", i), 64'(hazard1), 64'(vecs[i].eh1));
            check($sformatf("vec%0d_hazard2", i), 64'(hazard2), 64'(vecs[i].eh2));
        end
        check("waw_r7_final", 64'(rf[7]), 64'h0000BBBB);
        check("r6_final", 64'(rf[6]), 64'h00002222);
        check("r0_untouched", 64'(rf[0]), 64'h0);
`endif

`ifdef REGWR_BYPASS_EN
        // Bypass: empty buffer, idle writeback, result written in the same cycle.
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234);
        dec_raddr1 = 5'd9; dec_raddr2 = 5'd0;
        @(negedge clk);
        check("byp_we", 64'(we), 64'd1);
        check("byp_waddr", 64'(waddr), 64'd9);
        check("byp_wdata", 64'(wdata), 64'h1234);
        check("byp_pend", 64'(pend_cnt), 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
        @(negedge clk);
        check("byp_pend_after", 64'(pend_cnt), 64'd0);
        check("byp_hazard_after", 64'(hazard1), 64'd0);
        check("byp_zero_we", 64'(we), 64'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        dec_raddr1 = 5'd0;
`endif

        // Random stream, checked through the scoreboard; wb and lu address ranges never collide.
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sb_en = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick();
            drive(stall_req ? 1'b0 : 1'($urandom_range(0, 1)), 5'(16 + $urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'(24 + $urandom_range(0, 7)), $urandom);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        end
        @(negedge clk);
        sb_en = 1'b0;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("sb_pend_zero", 64'(pend_cnt), 64'd0);

        // Full buffer and starvation under continuous writeback.
        tick();
        drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd10, 32'hA0A0);
        tick();
        drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'hC0C0);
        rise_k = -1;
        for (int k = 0; k <= STARVE_MAX + 2; k++) begin
            tick();
            if (stall_req) begin
                rise_k = k;
                break;
            end
            drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd13, 32'hD0D0);
            if (k == 0) begin
                @(negedge clk);
                check("full_lu_ready", 64'(lu_ready), 64'd0);
                check("full_pend", 64'(pend_cnt), 64'd2);
            end
        end
        check("stall_rise_window", 64'((rise_k >= STARVE_MAX) && (rise_k <= STARVE_MAX + 1)), 64'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("stall_high", 64'(stall_req), 64'd1);
        check("stall_pop_we", 64'(we), 64'd1);
        check("stall_pop_addr", 64'(waddr), 64'd10);
        check("stall_pop_data", 64'(wdata), 64'hA0A0);
        tick();
        @(negedge clk);
        check("stall_fall", 64'(stall_req), 64'd0);
        check("second_pop_addr", 64'(waddr), 64'd12);
        check("second_pop_data", 64'(wdata), 64'hC0C0);
        check("second_pop_pend", 64'(pend_cnt), 64'd1);
        tick();
        @(negedge clk);
        check("starve_pend_zero", 64'(pend_cnt), 64'd0);

        // Asynchronous reset with r3 and r4 buffered: discarded, never written.
        tick();
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'h3333);
        tick();
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd4, 32'h4444);
        tick();
        drive(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'h0);
        dec_raddr1 = 5'd3; dec_raddr2 = 5'd4;
        #1;
        check("pre_rst_pend", 64'(pend_cnt), 64'd2);
        check("pre_rst_hazard1", 64'(hazard1), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", 64'(we), 64'd0);
        check("mid_rst_pend", 64'(pend_cnt), 64'd0);
        check("mid_rst_ready", 64'(lu_ready), 64'd0);
        check("mid_rst_hazard1", 64'(hazard1), 64'd0);
        check("mid_rst_hazard2", 64'(hazard2), 64'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        @(negedge clk);
        check("mid_rst_ready_hold", 64'(lu_ready), 64'd0);
        tick();
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(lu_ready), 64'd1);
        check("post_rst_we", 64'(we), 64'd0);
        check("post_rst_pend", 64'(pend_cnt), 64'd0);
        for (int c = 0; c < 4; c++) tick();
        check("rst_r3_unwritten", 64'(rf[3]), 64'h0);
        check("rst_r4_unwritten", 64'(rf[4]), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the register file's single write port between the MEM/WB writeback path and a long-latency execution unit (multiply/divide) result stream. Writeback always has priority. Long-latency results are held in a small in-order buffer and drained on idle write cycles. The block reports buffered destinations to decode as hazards and, after prolonged starvation, requests a pipeline stall.

## Interface
Parameters:
- DATA_W, 32, register data width (matches RegBus)
- ADDR_W, 5, register address width (matches RegAddrBus)
- DEPTH, 2, long-latency buffer entries (power of two, ≥2)
- STARVE_MAX, 8, consecutive blocked cycles before a stall is requested

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- wb_we  in  1  writeback write enable (priority source)
- wb_waddr  in  ADDR_W  writeback destination
- wb_wdata  in  DATA_W  writeback data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  buffer can accept a result
- lu_waddr  in  ADDR_W  long-latency destination
- lu_wdata  in  DATA_W  long-latency data
- we  out  1  register file write enable
- waddr  out  ADDR_W  register file write address
- wdata  out  DATA_W  register file write data
- dec_raddr1, dec_raddr2  in  ADDR_W  decode source addresses
- hazard1, hazard2  out  1  source address matches a live buffered entry
- stall_req  out  1  pipeline stall request (pipeline inserts a WB bubble)
- pend_cnt  out  log2(DEPTH)+1  occupied buffer entries

## Operation
- Buffer: circular FIFO with rd_ptr, wr_ptr, and count. Each entry holds {live, addr, data}.
- Accept: a result is accepted on a cycle with lu_valid && lu_ready. lu_ready = !full && !rst. It is combinational from state only and never depends on lu_valid.
- Address 0: an accepted result with lu_waddr == 0 is consumed without being stored or written.
- Port select:
  - If wb_we is high and stall_req is low, the port carries wb_*.
  - Otherwise, if the buffer is non-empty, the head pops. we = head.live, waddr/wdata = head fields.
  - Otherwise, we = 0.
- Outputs we/waddr/wdata are a combinational mux. A killed head pops with we = 0.
- WAW kill: when wb_we is high with wb_waddr != 0, every entry present at the start of that cycle with a matching addr has live cleared. An entry accepted in the same cycle is newer and stays live.
- Hazards: hazardN = (dec_raddrN != 0) && any live occupied entry has addr == dec_raddrN. This is combinational on current state.
- Starvation counter:
  - Increments each cycle the buffer is full and the head does not pop.
  - Clears when a pop occurs.
  - stall_req = (counter ≥ STARVE_MAX), registered, and held until the cycle after the head pops.
- Pipeline contract: wb_we is low while stall_req is high. If wb_we is high during stall_req, writeback data is dropped. The bench flags this as a protocol error.
- Simultaneous accept and pop on a full buffer is illegal, because lu_ready is low when full.

## Timing
- Reset (asynchronous): pointers, count, all live bits, starvation counter, and stall_req go to 0.
  - While rst is high: we=0, waddr=0, wdata=0, lu_ready=0, hazard1/2=0, pend_cnt=0.
- Writeback: zero latency; appears on we/waddr/wdata in the same cycle.
- Long-latency result: earliest write is the cycle after acceptance (default build).
- pend_cnt and hazards update on the clock edge after accept or pop.
- Reset asserted mid-operation discards all buffered entries without writing them.
- stall_req rises at most STARVE_MAX+1 cycles after the buffer becomes full under continuous writeback.

## Configuration
- REGWR_BYPASS_EN defined: in a cycle where the buffer is empty, wb_we is low, and lu_valid is high, the result writes directly to the port in that cycle. It is accepted but not stored, giving zero latency. Address 0 still produces we = 0.
- Not defined: every result is buffered; minimum latency is 1 cycle.

## Test plan
- Reset mid-stream, with 2 entries buffered (r3, r4) and rst pulsed asynchronously: no writes occur, pend_cnt=0, and lu_ready is 0 until rst falls.
- Priority: wb writes r5=0x1111 in the same cycle an lu result r6=0x2222 is accepted.
  - Cycle N: writes r5.
  - Cycle N+1 (wb idle): writes r6=0x2222.
- WAW kill: buffer holds r7=0xAAAA, then wb writes r7=0xBBBB.
  - Later pop gives we=0; r7 remains 0xBBBB.
  - hazard on r7 drops after the wb cycle.
- Full and starvation: fill 2 entries, then hold wb_we=1.
  - lu_ready=0.
  - stall_req rises after 8 blocked cycles.
  - With wb_we=0, the head pops, and stall_req falls the next cycle.
- Address zero and hazards: accepting lu_waddr=0 leaves pend_cnt unchanged with no write. dec_raddr1=0 never asserts hazard1.
- REGWR_BYPASS_EN: with the buffer empty and wb idle, lu r9=0x1234 is written in the same cycle and pend_cnt stays 0.
